mem_axi_lsu: RTL and testbench
==============================

MEM_AXI_LSU -- requirements
Module: mem_axi_lsu

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 13, AXI transaction ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, AXI data width; STRB_WIDTH = DATA_WIDTH/8.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid / req_ready  in / out  1  memory-stage request handshake; transfer when both are high.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  ADDR_WIDTH  byte address; this is the ALU result.
REQ-009 req_wdata  in  DATA_WIDTH  store data, rs2 value, LSB-justified.
REQ-010 req_funct3  in  3  RISC-V funct3; [1:0] is log2 of the size, [2] selects unsigned for loads.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  DATA_WIDTH  load result, extended to 64 bits; 0 for stores.
REQ-013 resp_err  out  1  bus error or illegal request; valid with resp_valid.
REQ-014 misalign  out  1  misaligned-request flag; valid with resp_valid.
REQ-015 m_axi_awid, m_axi_arid  out  ID_WIDTH  constant 1.
REQ-016 m_axi_awaddr, m_axi_araddr  out  ADDR_WIDTH  access address.
REQ-017 m_axi_awlen, m_axi_arlen  out  8  constant 0 (single beat).
REQ-018 m_axi_awsize, m_axi_arsize  out  3  {1'b0, funct3[1:0]}.
REQ-019 m_axi_awburst, m_axi_arburst  out  2  constant 2'b01 (INCR).
REQ-020 m_axi_awvalid/awready, m_axi_wvalid/wready, m_axi_arvalid/arready  out/in  1  address-channel and write-data-channel handshakes.
REQ-021 m_axi_wdata, m_axi_wstrb, m_axi_wlast  out  DATA_WIDTH, STRB_WIDTH, 1  write beat; wlast is constant 1.
REQ-022 m_axi_bvalid/bready, m_axi_bresp  in/out, in  1, 2  write response channel.
REQ-023 m_axi_rvalid/rready, m_axi_rdata, m_axi_rresp, m_axi_rlast  in/out, in, in, in  1, DATA_WIDTH, 2, 1  read data channel.

Function
REQ-024 The state machine SHALL have states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP and RESP.
- req_ready = 1 only in IDLE.
REQ-025 On an accepted request, the block SHALL register addr, wdata, funct3 and write, then move to RD_ADDR (load) or WR_REQ (store).
- arvalid, or awvalid together with wvalid, asserts the cycle after acceptance.
REQ-026 Every valid SHALL stay high until its own ready is seen; AW and W SHALL drop independently.
- WR_REQ exits to WR_RESP only once both AW and W have been accepted.
REQ-027 Address channel: RD_ADDR moves to RD_DATA on arvalid&arready.
- rready = 1 in RD_DATA; bready = 1 in WR_RESP.
REQ-028 Write beat:
- wdata = req_wdata << 8*addr[2:0].
- wstrb = ((1<<(1<<funct3[1:0]))-1) << addr[2:0], truncated to 8 bits.
REQ-029 Load result: shift rdata right by 8*addr[2:0], keep 1<<funct3[1:0] bytes, then extend.
- funct3[2] = 0: sign-extend. funct3[2] = 1: zero-extend.
- funct3 = 3'b111 is illegal: no bus traffic; resp_err = 1.
REQ-030 The first rvalid beat SHALL be accepted regardless of rlast.
REQ-031 RESP lasts exactly one cycle, then returns to IDLE.
- resp_valid pulses there, with resp_err = (xresp != 0).
- Minimum load latency: accept to resp_valid = 3 cycles with arready = 1 and rvalid returned the next cycle.
REQ-032 Store with funct3[2] = 1 is illegal: no bus traffic; resp_valid in the cycle after accept, with resp_err = 1.
REQ-033 resp_rdata, resp_err and misalign SHALL hold their value until the next RESP.

Reset
REQ-034 Reset SHALL force IDLE and clear all valids, readies and response outputs to 0 on the next edge.
- req_ready = 1 after the reset edge.
REQ-035 Reset during an outstanding transaction SHALL abandon it: no response is waited for, and no resp_valid is produced.

Configuration
REQ-036 With LSU_MISALIGN_CHECK_EN defined, an address not aligned to the access size SHALL produce no bus traffic.
- resp_valid = 1, resp_err = 1 and misalign = 1 in the cycle after accept.
REQ-037 With LSU_MISALIGN_CHECK_EN undefined, misalign SHALL be tied 0.
- The address is force-aligned: addr & ~(size-1) drives the bus and the lane shifts.

Verification
REQ-038 LD 0x1000, arready = 1, rdata = 0x1122334455667788 one cycle later -> resp_valid 3 cycles after accept, resp_rdata = 0x1122334455667788, resp_err = 0.
REQ-039 LB funct3 = 000, addr 0x1003, rdata byte3 = 0x80 -> resp_rdata = 0xFFFFFFFFFFFFFF80; LBU -> 0x0000000000000080.
REQ-040 SH addr 0x2002, wdata 0xBEEF, awready delayed 2 cycles, wready = 1 -> wstrb = 0x0C, wdata[31:16] = 0xBEEF, W drops first, bresp = 0 -> resp_err = 0.
REQ-041 LW addr 0x3002 -> with the macro: misalign = 1, resp_err = 1, no arvalid; without the macro: araddr = 0x3000.
REQ-042 Reset asserted while in RD_DATA -> arvalid/rready = 0 and req_ready = 1 after the edge; a later rvalid is ignored; no resp_valid.

Source files
------------

// File: rtl/mem_axi_lsu.sv
// mem_axi_lsu: RISC-V load/store unit turning memory-stage requests into single-beat AXI4 transfers.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned accesses; otherwise they are force-aligned.
module mem_axi_lsu #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [2:0]              req_funct3,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    misalign,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [1:0]              m_axi_bresp,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_WIDTH  = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;
    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [2:0]            funct3_q;
    logic                  write_q;
    logic                  aw_done, w_done;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q, misalign_q;

    logic [OFF_WIDTH-1:0]  req_low_mask;
    logic [ADDR_WIDTH-1:0] req_aligned_addr;
    logic                  req_illegal, req_misaligned, req_reject;
    logic [OFF_WIDTH-1:0]  off_q;
    logic [8:0]            size_bytes_mask;
    logic [DATA_WIDTH-1:0] lane_data, load_value;
    logic                  xfer_done;
    logic                  unused_rlast;

    assign req_low_mask     = OFF_WIDTH'((4'd1 << req_funct3[1:0]) - 4'd1);
    assign req_aligned_addr = {req_addr[ADDR_WIDTH-1:OFF_WIDTH], req_addr[OFF_WIDTH-1:0] & ~req_low_mask};
    // Loads have no unsigned doubleword form; stores never use funct3[2].
    assign req_illegal      = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
`ifdef LSU_MISALIGN_CHECK_EN
    assign req_misaligned   = (req_addr[OFF_WIDTH-1:0] & req_low_mask) != '0;
`else
    assign req_misaligned   = 1'b0;
`endif
    assign req_reject       = req_illegal | req_misaligned;

    assign off_q           = addr_q[OFF_WIDTH-1:0];
    assign size_bytes_mask = (9'd1 << (4'd1 << funct3_q[1:0])) - 9'd1;
    assign xfer_done       = ((state == RD_DATA) && m_axi_rvalid) || ((state == WR_RESP) && m_axi_bvalid);
    assign unused_rlast    = m_axi_rlast;

    always_comb begin
        lane_data = m_axi_rdata >> {off_q, 3'b000};
        case (funct3_q[1:0])
            2'd0:    load_value = {{(DATA_WIDTH-8){~funct3_q[2] & lane_data[7]}}, lane_data[7:0]};
            2'd1:    load_value = {{(DATA_WIDTH-16){~funct3_q[2] & lane_data[15]}}, lane_data[15:0]};
            2'd2:    load_value = {{(DATA_WIDTH-32){~funct3_q[2] & lane_data[31]}}, lane_data[31:0]};
            default: load_value = lane_data;
        endcase
    end

    assign m_axi_awid    = ID_WIDTH'(1);
    assign m_axi_arid    = ID_WIDTH'(1);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_awsize  = {1'b0, funct3_q[1:0]};
    assign m_axi_arsize  = {1'b0, funct3_q[1:0]};
    assign m_axi_awburst = 2'b01;
    assign m_axi_arburst = 2'b01;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wdata   = wdata_q << {off_q, 3'b000};
    assign m_axi_wstrb   = STRB_WIDTH'(size_bytes_mask) << off_q;
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign misalign      = misalign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= 3'd0;
            write_q    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && req_valid) begin
                addr_q   <= req_aligned_addr;
                wdata_q  <= req_wdata;
                funct3_q <= req_funct3;
                write_q  <= req_write;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
                if (req_reject) begin
                    rdata_q    <= '0;
                    err_q      <= 1'b1;
                    misalign_q <= req_misaligned;
                end
            end
            if ((state == WR_REQ) && m_axi_awready) aw_done <= 1'b1;
            if ((state == WR_REQ) && m_axi_wready)  w_done  <= 1'b1;
            // Response fields are captured on the completing handshake and held until the next one.
            if (xfer_done) begin
                rdata_q    <= write_q ? '0 : load_value;
                err_q      <= (write_q ? m_axi_bresp : m_axi_rresp) != 2'b00;
                misalign_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_reject ? RESP : (req_write ? WR_REQ : RD_ADDR);
            end
            RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_next = RD_DATA;
            end
            RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_next = RESP;
            end
            WR_REQ: begin
                m_axi_awvalid = ~aw_done;
                m_axi_wvalid  = ~w_done;
                if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_next = WR_RESP;
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_axi_lsu.sv
// Testbench for mem_axi_lsu: directed load/store scenarios plus randomized traffic against a
// transaction-level model of the address alignment, lane steering and extension rules.
module tb_mem_axi_lsu;
`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit MIS_CHECK = 1'b1;
`else
    localparam bit MIS_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_err, misalign;
    logic [63:0] resp_rdata;
    logic [12:0] m_axi_awid, m_axi_arid;
    logic [63:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen, m_axi_wstrb;
    logic [2:0]  m_axi_awsize, m_axi_arsize;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] lastRdata, lastAraddr;
    logic [7:0]  lastStrb;
    logic        lastMis;

    mem_axi_lsu dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .misalign(misalign),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference load semantics: pick the addressed bytes of the beat, then sign/zero extend.
    function automatic logic [63:0] loadModel(input logic [63:0] rd, input logic [63:0] addr, input logic [2:0] f3);
        longint unsigned nb;
        logic [63:0]     ea, v, m;
        nb = 64'd1 << f3[1:0];
        ea = addr - (addr % nb);
        v  = rd >> (8 * (ea % 8));
        if (nb < 8) begin
            m = (64'd1 << (8 * nb)) - 64'd1;
            v = v & m;
            if (!f3[2] && v[8*nb-1]) v = v | ~m;
        end
        return v;
    endfunction

    task automatic idleBus();
        m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
        m_axi_rvalid = 0; m_axi_bvalid = 0; m_axi_rresp = 0; m_axi_bresp = 0; m_axi_rlast = 0;
        m_axi_rdata = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1;
        idleBus();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    // One complete request; the bench plays an AXI slave with optional random ready/response delays.
    task automatic applyStimulus(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                                 input logic [2:0] f3, input bit fast, input int awDelayIn,
                                 input bit useFixed, input logic [63:0] rdFixed);
        longint unsigned nb;
        logic [63:0]     ea, expData;
        int              off, cyc;
        bit              illegal, mis, reject, expErr, gotResp, anyTraffic;
        bit              arFire, awFire, wFire, rFire, bFire, arDone, awDone, wDone, rDone, bDone;
        bit              arSeen, awSeen, wSeen;
        int              arWait, awWait, wWait, rWait, bWait;
        nb      = 64'd1 << f3[1:0];
        ea      = addr - (addr % nb);
        off     = int'(ea % 8);
        illegal = wr ? f3[2] : (f3 == 3'b111);
        mis     = (addr % nb) != 0;
        reject  = illegal || (MIS_CHECK && mis);
        expData = 64'd0;
        expErr  = reject;
        arWait  = fast ? 0 : $urandom_range(0, 3);
        awWait  = (awDelayIn >= 0) ? awDelayIn : (fast ? 0 : $urandom_range(0, 3));
        wWait   = fast ? 0 : $urandom_range(0, 3);
        rWait   = fast ? 0 : $urandom_range(0, 4);
        bWait   = fast ? 0 : $urandom_range(0, 4);

        @(negedge clk);
        checkOutput("req_ready_idle", req_ready, 1);
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd; req_funct3 = f3;
        while (!gotResp && cyc < 100) begin
            @(negedge clk);
            cyc++;
            req_valid = 0;
            if (arFire) arDone = 1;
            if (awFire) awDone = 1;
            if (wFire)  wDone  = 1;
            if (rFire) begin rDone = 1; m_axi_rvalid = 0; end
            if (bFire) begin bDone = 1; m_axi_bvalid = 0; end
            arFire = 0; awFire = 0; wFire = 0; rFire = 0; bFire = 0;
            if (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid) anyTraffic = 1;
            if (cyc == 1 && !reject) begin
                if (wr) checkOutput("aw_w_start", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
                else    checkOutput("ar_start", m_axi_arvalid, 1);
            end
            if (resp_valid) begin
                gotResp   = 1;
                lastRdata = resp_rdata;
                lastMis   = misalign;
                checkOutput("resp_rdata", resp_rdata, expData);
                checkOutput("resp_err", resp_err, expErr);
                checkOutput("misalign", misalign, MIS_CHECK && mis);
                checkOutput("resp_req_ready", req_ready, 0);
                if (reject) begin
                    checkOutput("reject_latency", cyc, 1);
                    checkOutput("reject_no_traffic", anyTraffic, 0);
                end else if (fast && !wr) begin
                    checkOutput("load_latency", cyc, 3);
                end else begin
                    checkOutput("resp_after_xfer", wr ? bDone : rDone, 1);
                end
            end else begin
                if (m_axi_arvalid && !arSeen) begin
                    arSeen = 1;
                    lastAraddr = m_axi_araddr;
                    checkOutput("araddr", m_axi_araddr, ea);
                    checkOutput("arsize", m_axi_arsize, {1'b0, f3[1:0]});
                end
                m_axi_arready = (arWait == 0);
                if (m_axi_arvalid && arWait > 0) arWait--;
                arFire = m_axi_arvalid && m_axi_arready;

                if (m_axi_awvalid && !awSeen) begin
                    awSeen = 1;
                    checkOutput("awaddr", m_axi_awaddr, ea);
                    checkOutput("awsize", m_axi_awsize, {1'b0, f3[1:0]});
                end
                m_axi_awready = (awWait == 0);
                if (m_axi_awvalid && awWait > 0) awWait--;
                awFire = m_axi_awvalid && m_axi_awready;

                if (m_axi_wvalid && !wSeen) begin
                    wSeen = 1;
                    lastStrb = m_axi_wstrb;
                    checkOutput("wdata", m_axi_wdata, wd << (8 * off));
                    checkOutput("wstrb", m_axi_wstrb, 8'(((16'd1 << nb) - 16'd1) << off));
                    checkOutput("wlast", m_axi_wlast, 1);
                end
                m_axi_wready = (wWait == 0);
                if (m_axi_wvalid && wWait > 0) wWait--;
                wFire = m_axi_wvalid && m_axi_wready;

                if (wDone && !awDone) begin
                    checkOutput("w_dropped", m_axi_wvalid, 0);
                    checkOutput("aw_held", m_axi_awvalid, 1);
                end
                if (awDone && !wDone) begin
                    checkOutput("aw_dropped", m_axi_awvalid, 0);
                    checkOutput("w_held", m_axi_wvalid, 1);
                end

                if (arDone && !rDone && !m_axi_rvalid) begin
                    if (rWait > 0) rWait--;
                    else begin
                        m_axi_rvalid = 1;
                        m_axi_rdata  = useFixed ? rdFixed : {$urandom, $urandom};
                        m_axi_rresp  = (fast || $urandom_range(0, 5) != 0) ? 2'b00 : 2'b10;
                        m_axi_rlast  = 1'($urandom_range(0, 1));
                        expData      = loadModel(m_axi_rdata, addr, f3);
                        expErr       = (m_axi_rresp != 2'b00);
                        checkOutput("rready", m_axi_rready, 1);
                    end
                end
                rFire = m_axi_rvalid && m_axi_rready;

                if (awDone && wDone && !bDone && !m_axi_bvalid) begin
                    if (bWait > 0) bWait--;
                    else begin
                        m_axi_bvalid = 1;
                        m_axi_bresp  = (fast || $urandom_range(0, 5) != 0) ? 2'b00 : 2'b10;
                        expErr       = (m_axi_bresp != 2'b00);
                    end
                end
                bFire = m_axi_bvalid && m_axi_bready;
            end
        end
        m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
        if (!gotResp) begin
            checkOutput("resp_timeout", gotResp, 1);
            resetDut();
        end else begin
            @(negedge clk);
            checkOutput("resp_pulse_end", resp_valid, 0);
            checkOutput("ready_after_resp", req_ready, 1);
            checkOutput("rdata_held", resp_rdata, expData);
            checkOutput("err_held", resp_err, expErr);
        end
    endtask

    initial begin
        reset = 1;
        idleBus();
        repeat (2) @(negedge clk);
        reset = 0;
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, resp_valid}, 0);
        checkOutput("rst_readies", {m_axi_rready, m_axi_bready}, 0);
        checkOutput("rst_resp", {resp_rdata, resp_err, misalign}, 0);
        checkOutput("const_len_burst", {m_axi_arlen, m_axi_awlen, m_axi_arburst, m_axi_awburst}, 20'h00005);
        checkOutput("const_ids_wlast", {m_axi_arid, m_axi_awid, m_axi_wlast}, {13'd1, 13'd1, 1'b1});

        applyStimulus(0, 64'h1000, 64'h0, 3'b011, 1, -1, 1, 64'h1122334455667788);
        checkOutput("ld_value", lastRdata, 64'h1122334455667788);
        applyStimulus(0, 64'h1003, 64'h0, 3'b000, 1, -1, 1, 64'h1122334480667788);
        checkOutput("lb_value", lastRdata, 64'hFFFFFFFFFFFFFF80);
        applyStimulus(0, 64'h1003, 64'h0, 3'b100, 1, -1, 1, 64'h1122334480667788);
        checkOutput("lbu_value", lastRdata, 64'h0000000000000080);
        applyStimulus(1, 64'h2002, 64'hBEEF, 3'b001, 1, 2, 0, 64'h0);
        checkOutput("sh_wstrb", lastStrb, 8'h0C);
        applyStimulus(0, 64'h3002, 64'h0, 3'b010, 1, -1, 1, 64'hCAFEF00D12345678);
`ifdef LSU_MISALIGN_CHECK_EN
        checkOutput("lw_misalign", lastMis, 1);
`else
        checkOutput("lw_araddr", lastAraddr, 64'h3000);
`endif
        applyStimulus(0, 64'h4000, 64'h0, 3'b111, 1, -1, 1, 64'h0);
        applyStimulus(1, 64'h4008, 64'h1234, 3'b110, 1, -1, 0, 64'h0);

        // Reset while the DUT waits in RD_DATA: the transaction must be abandoned silently.
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 64'h5000; req_funct3 = 3'b011;
        @(negedge clk);
        req_valid = 0;
        m_axi_arready = 1;
        @(negedge clk);
        m_axi_arready = 0;
        checkOutput("pre_reset_rready", m_axi_rready, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        checkOutput("mid_rst_arvalid", m_axi_arvalid, 0);
        checkOutput("mid_rst_rready", m_axi_rready, 0);
        checkOutput("mid_rst_req_ready", req_ready, 1);
        checkOutput("mid_rst_resp", {resp_rdata, resp_err}, 0);
        m_axi_rvalid = 1; m_axi_rdata = 64'hDEADBEEFDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("late_rvalid_resp", resp_valid, 0);
            checkOutput("late_rvalid_ready", req_ready, 1);
        end
        m_axi_rvalid = 0;

        for (int n = 0; n < 60; n++) begin
            logic [63:0] a, d;
            logic [2:0]  f;
            logic        w;
            a = {48'h0, 16'($urandom)};
            d = {$urandom, $urandom};
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            applyStimulus(w, a, d, f, 0, -1, 0, 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
